// File: rtl/pc_next_if.sv
// Control-flow bundle between decode/execute and the next-PC unit.
interface pc_next_if #(
    parameter int unsigned AW        = 8,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [AW-1:0] pc_in;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_offset;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          call;
    logic          ret;
    logic          clr_flags;
    logic [AW-1:0] pc_next;
    logic [CW-1:0] ras_count;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output pc_in, stall, branch_taken, branch_offset, jump, jump_target,
               call, ret, clr_flags,
        input  pc_next, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  pc_in, stall, branch_taken, branch_offset, jump, jump_target,
               call, ret, clr_flags,
        output pc_next, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC selection with a circular return-address stack and sticky RAS error flags.
// The RAS is built only when PC_NEXT_RAS_EN is defined; otherwise call acts as jump and ret as sequential.
module pc_next_unit #(
    parameter int unsigned AW        = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     reset,
    pc_next_if.slave bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [AW-1:0] pc_inc_c;
    logic [AW-1:0] pc_next_c;
    logic          ret_hit_c;
    logic [AW-1:0] top_addr_c;

    assign pc_inc_c = bus.pc_in + AW'(1);

    // Priority mux: stall > ret > call > jump > branch > sequential
    always_comb begin
        pc_next_c = pc_inc_c;
        if (bus.stall) begin
            pc_next_c = bus.pc_in;
        end else if (bus.ret) begin
            pc_next_c = ret_hit_c ? top_addr_c : pc_inc_c;
        end else if (bus.call || bus.jump) begin
            pc_next_c = bus.jump_target;
        end else if (bus.branch_taken) begin
            pc_next_c = bus.pc_in + bus.branch_offset;
        end
    end

    assign bus.pc_next = pc_next_c;

`ifdef PC_NEXT_RAS_EN
    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] top_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          unf_q;
    logic          empty_c;
    logic          full_c;
    logic          push_c;
    logic          pop_c;
    logic          ovf_evt_c;
    logic          unf_evt_c;

    always_comb begin
        empty_c   = (count_q == '0);
        full_c    = (count_q == CW'(RAS_DEPTH));
        push_c    = !bus.stall && !bus.ret && bus.call;
        pop_c     = !bus.stall && bus.ret && !empty_c;
        ovf_evt_c = push_c && full_c;
        unf_evt_c = !bus.stall && bus.ret && empty_c;
        ret_hit_c = !empty_c;
        top_addr_c = ras_mem[top_q];
    end

    // A push into a full stack lands on the oldest slot, so count saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                ras_mem[top_q + PW'(1)] <= pc_inc_c;
                top_q                   <= top_q + PW'(1);
                if (!full_c) begin
                    count_q <= count_q + CW'(1);
                end
            end else if (pop_c) begin
                top_q   <= top_q - PW'(1);
                count_q <= count_q - CW'(1);
            end
            ovf_q <= ovf_evt_c || (ovf_q && !bus.clr_flags);
            unf_q <= unf_evt_c || (unf_q && !bus.clr_flags);
        end
    end

    assign bus.ras_count     = count_q;
    assign bus.ras_empty     = empty_c;
    assign bus.ras_full      = full_c;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
`else
    logic unused_inputs;

    assign ret_hit_c     = 1'b0;
    assign top_addr_c    = pc_inc_c;
    assign unused_inputs = ^{clk, reset, bus.clr_flags};

    assign bus.ras_count     = '0;
    assign bus.ras_empty     = 1'b1;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_overflow  = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit against a queue-based stack model.
module tb_pc_next_unit;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef PC_NEXT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pc_next_if #(.AW(AW), .RAS_DEPTH(DEPTH)) bus ();
    pc_next_unit #(.AW(AW), .RAS_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: newest return address at the back of the queue
    logic [AW-1:0] stk [$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    function automatic void model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [AW-1:0] exp_pc();
        logic [AW-1:0] inc;
        inc = bus.pc_in + 8'd1;
        if (bus.stall) return bus.pc_in;
        if (bus.ret) return (RAS_EN && stk.size() > 0) ? stk[$] : inc;
        if (bus.call || bus.jump) return bus.jump_target;
        if (bus.branch_taken) return bus.pc_in + bus.branch_offset;
        return inc;
    endfunction

    function automatic void model_edge();
        bit ev_o;
        bit ev_u;
        logic [AW-1:0] inc;
        ev_o = 1'b0;
        ev_u = 1'b0;
        inc  = bus.pc_in + 8'd1;
        if (!bus.stall && RAS_EN) begin
            if (bus.ret) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else ev_u = 1'b1;
            end else if (bus.call) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    ev_o = 1'b1;
                end
                stk.push_back(inc);
            end
        end
        m_ovf = ev_o || (m_ovf && !bus.clr_flags);
        m_unf = ev_u || (m_unf && !bus.clr_flags);
    endfunction

    task automatic set_in(input logic [AW-1:0] pc, input bit st, input bit rt, input bit cl,
                          input bit jp, input bit br, input logic [AW-1:0] off,
                          input logic [AW-1:0] tgt, input bit clr);
        bus.pc_in         = pc;
        bus.stall         = st;
        bus.ret           = rt;
        bus.call          = cl;
        bus.jump          = jp;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump_target   = tgt;
        bus.clr_flags     = clr;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(8'h10, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        #2;
        n_tests++; if (bus.pc_next !== 8'h11) begin n_fail++; $display("FAIL reset_pc_next: got %h expected 11", bus.pc_next); end
        n_tests++; if (bus.ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.ras_count); end
        n_tests++; if ({bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_status: got %b expected 1000",
                               {bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [AW-1:0] pc;
        for (int i = 0; i < 10; i++) begin
            pc = (i == 0) ? 8'h10 : (i == 1) ? 8'hFF : 8'($urandom);
            set_in(pc, 0, 0, 0, 0, 0, 8'($urandom), 8'($urandom), 0);
            #1;
            n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL seq pc=%h: got %h expected %h", pc, bus.pc_next, exp_pc()); end
            tick();
        end
    endtask

    task automatic test_priority();
        bit [2:0] ctl;
        for (int i = 0; i < 12; i++) begin
            // First three follow the branch -> +jump -> +stall ladder
            ctl = (i == 0) ? 3'b001 : (i == 1) ? 3'b011 : (i == 2) ? 3'b111 : 3'($urandom);
            if (i < 3) set_in(8'h20, ctl[2], 0, 0, ctl[1], ctl[0], 8'hF0, 8'h80, 0);
            else set_in(8'($urandom), ctl[2], 0, 0, ctl[1], ctl[0], 8'($urandom), 8'($urandom), 0);
            #1;
            n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL priority ctl=%b: got %h expected %h", ctl, bus.pc_next, exp_pc()); end
            tick();
        end
    endtask

    task automatic test_call_ret();
        set_in(8'h05, 0, 0, 1, 0, 0, 8'h00, 8'h40, 0);
        #1;
        n_tests++; if (bus.pc_next !== 8'h40) begin n_fail++; $display("FAIL call_pc: got %h expected 40", bus.pc_next); end
        tick();
        n_tests++; if (bus.ras_count !== 3'(stk.size())) begin n_fail++; $display("FAIL call_count: got %0d expected %0d", bus.ras_count, stk.size()); end
        set_in(8'h41, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        #1;
        n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL ret_pc: got %h expected %h", bus.pc_next, exp_pc()); end
        tick();
        n_tests++; if (bus.ras_count !== 3'(stk.size())) begin n_fail++; $display("FAIL ret_count: got %0d expected %0d", bus.ras_count, stk.size()); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            set_in(8'(i), 0, 0, 1, 0, 0, 8'h00, 8'($urandom), 0);
            #1;
            n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL ovf_call%0d: got %h expected %h", i, bus.pc_next, exp_pc()); end
            tick();
        end
        n_tests++; if ({bus.ras_full, bus.ras_overflow} !== {RAS_EN, m_ovf}) begin
            n_fail++; $display("FAIL ovf_flags: got %b expected %b", {bus.ras_full, bus.ras_overflow}, {RAS_EN, m_ovf}); end
        for (int i = 0; i < 5; i++) begin
            set_in(8'($urandom), 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
            #1;
            n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL ovf_ret%0d: got %h expected %h", i, bus.pc_next, exp_pc()); end
            tick();
        end
        n_tests++; if ({bus.ras_empty, bus.ras_underflow} !== {1'b1, m_unf}) begin
            n_fail++; $display("FAIL unf_flags: got %b expected %b", {bus.ras_empty, bus.ras_underflow}, {1'b1, m_unf}); end
    endtask

    task automatic test_flags();
        bit [2:0] seq [3] = '{3'b001, 3'b011, 3'b111}; // {stall, ret, clr}
        for (int i = 0; i < 3; i++) begin
            set_in(8'h33, seq[i][2], seq[i][1], 0, 0, 0, 8'h00, 8'h00, seq[i][0]);
            tick();
            n_tests++; if ({bus.ras_overflow, bus.ras_underflow} !== {m_ovf, m_unf}) begin
                n_fail++; $display("FAIL flags_step%0d: got %b expected %b", i, {bus.ras_overflow, bus.ras_underflow}, {m_ovf, m_unf}); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            set_in(8'(8'h50 + i), 0, 0, 1, 0, 0, 8'h00, 8'h60, 0);
            tick();
        end
        set_in(8'h60, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++; if ({bus.ras_count, bus.ras_empty} !== {3'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_mid: got count %0d empty %b expected 0 1", bus.ras_count, bus.ras_empty); end
        @(negedge clk);
        reset = 1'b0;
        set_in(8'h30, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        #1;
        n_tests++; if (bus.pc_next !== 8'h31) begin n_fail++; $display("FAIL post_reset_ret: got %h expected 31", bus.pc_next); end
        tick();
        n_tests++; if (bus.ras_underflow !== m_unf) begin n_fail++; $display("FAIL post_reset_unf: got %b expected %b", bus.ras_underflow, m_unf); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 500; i++) begin
            set_in(8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                   8'($urandom), 8'($urandom), $urandom_range(0, 11) == 0);
            #1;
            n_tests++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL rand_pc cyc%0d: got %h expected %h", i, bus.pc_next, exp_pc()); end
            tick();
            n_tests++; if ({bus.ras_count, bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow} !==
                           {3'(stk.size()), stk.size() == 0, stk.size() == DEPTH, m_ovf, m_unf}) begin
                n_fail++; $display("FAIL rand_state cyc%0d: got %b expected %b", i,
                    {bus.ras_count, bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow},
                    {3'(stk.size()), stk.size() == 0, stk.size() == DEPTH, m_ovf, m_unf}); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_priority();
        test_call_ret();
        test_overflow();
        test_flags();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Next-PC generation stage for the 8-bit RISC CPU. It sits directly upstream of the program-counter register: it takes the current PC and the decode/execute control flow signals, and it produces the `pc_next` value that the PC register loads on the following clock edge. It contains a return-address stack (RAS) for call and return instructions, plus sticky error flags that diagnostic logic can read.

## Interface
Parameters:
- `AW`, 8: address width; must match the PC register width.
- `RAS_DEPTH`, 4: number of RAS entries; must be a power of two and at least 2.

Ports:
- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-high.
- `pc_in`  input  AW  current PC, taken from the PC register output.
- `stall`  input  1  hold the PC and freeze the RAS.
- `branch_taken`  input  1  apply a conditional PC-relative branch.
- `branch_offset`  input  AW  two's-complement offset, added to `pc_in`.
- `jump`  input  1  apply an absolute jump.
- `jump_target`  input  AW  absolute target for `jump` and `call`.
- `call`  input  1  push `pc_in+1`, then go to `jump_target`.
- `ret`  input  1  pop the top of the RAS into `pc_next`.
- `clr_flags`  input  1  synchronous clear of the sticky flags.
- `pc_next`  output  AW  next PC value (combinational).
- `ras_count`  output  $clog2(RAS_DEPTH)+1  number of valid entries.
- `ras_empty`  output  1  `ras_count == 0`.
- `ras_full`  output  1  `ras_count == RAS_DEPTH`.
- `ras_overflow`  output  1  sticky; set when a call pushes while the RAS is full.
- `ras_underflow`  output  1  sticky; set when a ret pops while the RAS is empty.

## Operation
- Priority, highest first: `stall` > `ret` > `call` > `jump` > `branch_taken` > sequential. Only the winning action takes effect; all lower-priority inputs are ignored in that cycle.
- Sequential: `pc_next = pc_in + 1`.
- Branch: `pc_next = pc_in + branch_offset`.
- Jump: `pc_next = jump_target`.
- Stall: `pc_next = pc_in`; no RAS or flag update, except that `clr_flags` is still honoured.
- Call:
  - `pc_next = jump_target`.
  - `pc_in+1` is pushed onto the RAS.
  - If the RAS is full, the push is circular: the oldest entry is overwritten, `ras_count` stays at `RAS_DEPTH`, and `ras_overflow` is set.
- Ret:
  - If the RAS is non-empty, `pc_next` = top entry and `ras_count` decrements.
  - If the RAS is empty, `pc_next = pc_in + 1`, `ras_count` stays 0, and `ras_underflow` is set.
- Arithmetic: all adds are modulo 2^AW. `8'hFF + 1 = 8'h00`, and `8'h02 + 8'hFC = 8'hFE`.
- RAS organisation: circular buffer with a top pointer of `$clog2(RAS_DEPTH)` bits that wraps modulo `RAS_DEPTH`. A push writes to `top+1` and advances the pointer; a pop reads `top` and retreats the pointer.
- `clr_flags`:
  - Clears both sticky flags at the clock edge.
  - If a flag-setting event happens in the same cycle, set wins.
- Reset values: `ras_count=0`, top pointer 0, all entries 0, `ras_overflow=0`, `ras_underflow=0`, `ras_empty=1`, `ras_full=0`. `pc_next` is combinational; under reset with no control inputs asserted it equals `pc_in+1`.

## Timing
- `pc_next` is purely combinational from the inputs and the current RAS top; there is zero-cycle latency to the PC register input.
- The RAS pointer, `ras_count` and the flags update on the rising edge of `clk` and are visible in the next cycle.
- Back-to-back call/ret in consecutive cycles is supported. A ret in the cycle after a call returns the just-pushed address.
- Reset asserted mid-operation clears the RAS immediately (asynchronously). A ret in the first cycle after reset release is an underflow.

## Configuration
- Macro: `PC_NEXT_RAS_EN`.
- Defined: full RAS behaviour as specified above.
- Not defined:
  - No RAS storage is built.
  - `call` behaves exactly as `jump`.
  - `ret` behaves as sequential (`pc_in+1`).
  - `ras_count=0`, `ras_empty=1`, `ras_full=0`, `ras_overflow=0`, `ras_underflow=0` as constants.
  - The priority order is otherwise unchanged.

## Test plan
- Sequential and wrap:
  - `pc_in=8'h10`, no controls -> `pc_next=8'h11`.
  - `pc_in=8'hFF` -> `pc_next=8'h00`.
- Branch/jump priority:
  - `pc_in=8'h20`, `branch_taken=1`, `branch_offset=8'hF0` -> `8'h10`.
  - Add `jump=1`, `jump_target=8'h80` -> `8'h80`.
  - Add `stall=1` -> `8'h20`.
- Call/ret round trip:
  - `pc_in=8'h05`, `call=1`, `jump_target=8'h40` -> `pc_next=8'h40`, then `ras_count=1`.
  - Next cycle `pc_in=8'h41`, `ret=1` -> `pc_next=8'h06`, then `ras_count=0`.
- Overflow (`RAS_DEPTH=4`):
  - Calls from `pc_in` 1, 2, 3, 4, 5 -> `ras_overflow=1`, `ras_full=1`.
  - Four rets return 6, 5, 4, 3 in that order.
  - A fifth ret gives `pc_in+1` and sets `ras_underflow=1`.
- Flags and reset:
  - `clr_flags=1` -> both flags clear next cycle.
  - `clr_flags` with a simultaneous underflow -> `ras_underflow` stays 1.
  - Reset pulse mid-stack -> `ras_count=0` immediately.
- Macro off: `call`, `jump_target=8'h40`, `pc_in=8'h05` -> `pc_next=8'h40`, `ras_count=0`. Next `ret` with `pc_in=8'h40` -> `8'h41`, no flags set.
